// File: rtl/sram_controller_pkg.sv
// Shared encodings and geometry for the SRAM controller: FSM states, SRAM bus widths,
// and the number of 16-bit words moved per line read and per word write.
package sram_controller_pkg;

  localparam logic [1:0] S_SRAM_IDLE  = 2'd0;
  localparam logic [1:0] S_SRAM_READ  = 2'd1;
  localparam logic [1:0] S_SRAM_WRITE = 2'd2;
  localparam logic [1:0] S_SRAM_DONE  = 2'd3;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DQ_W   = 16;

  localparam int LINE_WORDS  = 4;
  localparam int WRITE_WORDS = 2;

  localparam logic [1:0] LINE_LAST_IDX  = 2'(LINE_WORDS - 1);
  localparam logic [1:0] WRITE_LAST_IDX = 2'(WRITE_WORDS - 1);

endpackage

// File: rtl/sram_access_counter.sv
// Completed read and write access counters; each increments on its strobe and wraps at 2^32.
module sram_access_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_inc,
  input  logic        wr_inc,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_inc) rd_count <= rd_count + 32'd1;
      if (wr_inc) wr_count <= wr_count + 32'd1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Cache-side controller for a 16-bit async SRAM: 64-bit line reads, 32-bit word writes,
// one-cycle ready pulse on completion. Access counters built only with `SRAM_ACCESS_COUNTER_EN.
module sram_controller #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        read_en,
  input  logic        write_en,
  output logic [63:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  import sram_controller_pkg::*;

  localparam int                WAIT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACCESS_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           idx;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 word_done;
  logic [SRAM_DQ_W-1:0] dq_out;
  logic                 unused_addr_bits;

  assign word_done        = (wait_cnt == WAIT_LAST);
  assign unused_addr_bits = ^{addr[31:19], addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SRAM_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      read_data <= '0;
    end else begin
      case (state)
        S_SRAM_IDLE: begin
          idx      <= '0;
          wait_cnt <= '0;
          if (write_en)     state <= S_SRAM_WRITE;
          else if (read_en) state <= S_SRAM_READ;
        end
        S_SRAM_READ: begin
          if (word_done) begin
            // Sample at the end of the hold window so the SRAM output has settled.
            read_data[SRAM_DQ_W*idx +: SRAM_DQ_W] <= SRAM_DQ;
            wait_cnt <= '0;
            if (idx == LINE_LAST_IDX) state <= S_SRAM_DONE;
            else                      idx   <= idx + 2'd1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_SRAM_WRITE: begin
          if (word_done) begin
            wait_cnt <= '0;
            if (idx == WRITE_LAST_IDX) state <= S_SRAM_DONE;
            else                       idx   <= idx + 2'd1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= S_SRAM_IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    case (state)
      S_SRAM_READ:  SRAM_ADDR = {addr[18:3], idx};
      S_SRAM_WRITE: SRAM_ADDR = {addr[18:2], idx[0]};
      default:      SRAM_ADDR = '0;
    endcase
  end

  // WE_N rises on the last cycle of each word so address and data outlast the strobe.
  assign SRAM_WE_N = !((state == S_SRAM_WRITE) && !word_done);
  assign SRAM_OE_N = (state != S_SRAM_READ);
  assign dq_out    = idx[0] ? write_data[31:16] : write_data[15:0];
  assign SRAM_DQ   = (state == S_SRAM_WRITE) ? dq_out : {SRAM_DQ_W{1'bz}};
  assign ready     = (state == S_SRAM_DONE);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

`ifdef SRAM_ACCESS_COUNTER_EN
  logic is_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       is_write <= 1'b0;
    else if (state == S_SRAM_IDLE) is_write <= write_en;
  end

  sram_access_counter u_access_counter (
    .clk      (clk),
    .rst      (rst),
    .rd_inc   (ready && !is_write),
    .wr_inc   (ready && is_write),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller with a behavioural 256Kx16 SRAM, ACCESS_CYCLES=2.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        read_en;
  logic        write_en;
  logic [63:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [31:0] rd_count, wr_count;

  int n_checks = 0;
  int n_pass   = 0;

  sram_controller #(.ACCESS_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .write_data (write_data),
    .read_en    (read_en),
    .write_en   (write_en),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  initial forever #5 clk = ~clk;

  // Behavioural SRAM; the preload port lets the test seed contents.
  logic [15:0] mem [0:262143];
  logic        pre_we = 1'b0;
  logic [17:0] pre_addr = '0;
  logic [15:0] pre_dat = '0;

  assign sram_dq = (!sram_oe_n && sram_we_n && !sram_ce_n) ? mem[sram_addr] : 16'bz;

  always @(negedge clk) begin
    if (pre_we)          mem[pre_addr]  <= pre_dat;
    else if (!sram_we_n) mem[sram_addr] <= sram_dq;
  end

  typedef struct {
    int          lat;
    logic [63:0] rdata;
    bit          is_read;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          op;     // 0 read, 1 write, 2 read+write together
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [63:0] rd;
    logic [17:0] maddr;
    logic [15:0] m0;
    logic [15:0] m1;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run_req(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input int drop_at, input string name, input int exp_lat,
                         input logic [63:0] exp_rd);
    exp_t        e;
    int          lat;
    int          oe_low;
    bit          seen;
    logic [63:0] rd_cap;
    e.lat     = exp_lat;
    e.rdata   = exp_rd;
    e.is_read = (op == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    addr       = a;
    write_data = wd;
    read_en    = (op != 1);
    write_en   = (op != 0);
    seen = 0; lat = 0; oe_low = 0; rd_cap = '0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (n == drop_at) begin read_en = 1'b0; write_en = 1'b0; end
      @(negedge clk);
      if (!sram_oe_n) oe_low++;
      if (ready) begin
        seen = 1; lat = n; rd_cap = read_data;
        read_en = 1'b0; write_en = 1'b0;
      end
    end
    if (!seen) begin read_en = 1'b0; write_en = 1'b0; end
    e = sb.pop_front();
    check({name, "_latency"}, 64'(lat), 64'(e.lat));
    if (e.is_read) check({name, "_rdata"}, rd_cap, e.rdata);
    if (op == 2)   check({name, "_oe_low_cycles"}, 64'(oe_low), 64'd0);
    @(negedge clk);
    check({name, "_single_ready"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int ready_seen;
    int exp_rd_cnt, exp_wr_cnt;

    vecs[0] = '{0, 32'h0000_0104, 32'h0,         9, 64'h4444_3333_2222_1111, 18'h0,     16'h0,    16'h0};
    vecs[1] = '{1, 32'h0000_0100, 32'hDEAD_BEEF, 5, 64'h0,                   18'h00080, 16'hBEEF, 16'hDEAD};
    vecs[2] = '{0, 32'h0000_0107, 32'h0,         9, 64'h4444_3333_DEAD_BEEF, 18'h0,     16'h0,    16'h0};
    vecs[3] = '{2, 32'h0000_0203, 32'h1234_5678, 5, 64'h0,                   18'h00100, 16'h5678, 16'h1234};
    vecs[4] = '{0, 32'h0000_0200, 32'h0,         9, 64'hBBBB_AAAA_1234_5678, 18'h0,     16'h0,    16'h0};
    vecs[5] = '{0, 32'h0007_FFFC, 32'h0,         9, 64'h0607_0405_0203_0001, 18'h0,     16'h0,    16'h0};

    rst = 1'b1; addr = '0; write_data = '0; read_en = 1'b0; write_en = 1'b0;
    preload(18'h00080, 16'h1111);
    preload(18'h00081, 16'h2222);
    preload(18'h00082, 16'h3333);
    preload(18'h00083, 16'h4444);
    preload(18'h00102, 16'hAAAA);
    preload(18'h00103, 16'hBBBB);
    preload(18'h3FFFC, 16'h0001);
    preload(18'h3FFFD, 16'h0203);
    preload(18'h3FFFE, 16'h0405);
    preload(18'h3FFFF, 16'h0607);

    check("rst_ready",     64'(ready),     64'd0);
    check("rst_we_n",      64'(sram_we_n), 64'd1);
    check("rst_oe_n",      64'(sram_oe_n), 64'd1);
    check("rst_sram_addr", 64'(sram_addr), 64'd0);
    check("rst_read_data", read_data,      64'd0);
    check("rst_rd_count",  64'(rd_count),  64'd0);
    check("rst_ce_ub_lb",  64'({sram_ce_n, sram_ub_n, sram_lb_n}), 64'd0);

    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a line read: immediate return to reset values, no ready.
    @(posedge clk);
    #1; addr = 32'h104; read_en = 1'b1;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; read_en = 1'b0;
    #1;
    check("abort_ready",     64'(ready),     64'd0);
    check("abort_oe_n",      64'(sram_oe_n), 64'd1);
    check("abort_we_n",      64'(sram_we_n), 64'd1);
    check("abort_sram_addr", 64'(sram_addr), 64'd0);
    check("abort_read_data", read_data,      64'd0);
    ready_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) ready_seen++;
    end
    check("abort_no_ready", 64'(ready_seen), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_req(0, 32'h104, 32'h0, 0, "post_reset_read", 9, 64'h4444_3333_2222_1111);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].op, vecs[i].a, vecs[i].wd, 0, $sformatf("vec%0d", i),
              vecs[i].lat, vecs[i].rd);
      if (vecs[i].op != 0) begin
        check($sformatf("vec%0d_mem_lo", i), 64'(mem[vecs[i].maddr]),       64'(vecs[i].m0));
        check($sformatf("vec%0d_mem_hi", i), 64'(mem[vecs[i].maddr + 18'd1]), 64'(vecs[i].m1));
      end
    end

    // Enable dropped after the first cycle: the write still completes.
    run_req(1, 32'h400, 32'h0BAD_F00D, 1, "drop_write", 5, 64'h0);
    check("drop_write_mem_lo", 64'(mem[18'h00200]), 64'h0000_F00D);
    check("drop_write_mem_hi", 64'(mem[18'h00201]), 64'h0000_0BAD);
    run_req(0, 32'h100, 32'h0, 0, "after_drop_read", 9, 64'h4444_3333_DEAD_BEEF);

`ifdef SRAM_ACCESS_COUNTER_EN
    exp_rd_cnt = 6;
    exp_wr_cnt = 3;
`else
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
`endif
    @(negedge clk);
    check("rd_count", 64'(rd_count), 64'(exp_rd_cnt));
    check("wr_count", 64'(wr_count), 64'(exp_wr_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
